// File: rtl/memory_controller_pkg.sv
// Shared widths, op encodings and state codes for the memory controller and its helpers.
package memory_controller_pkg;

  localparam int unsigned DataWidth  = 32;
  localparam int unsigned OpWidth    = 4;
  localparam int unsigned RobIdWidth = 4;
  localparam logic [31:0] IoBase     = 32'h0003_0000;

  localparam logic [OpWidth-1:0] OpLb  = 4'd0;
  localparam logic [OpWidth-1:0] OpLh  = 4'd1;
  localparam logic [OpWidth-1:0] OpLw  = 4'd2;
  localparam logic [OpWidth-1:0] OpLbu = 4'd3;
  localparam logic [OpWidth-1:0] OpLhu = 4'd4;
  localparam logic [OpWidth-1:0] OpSb  = 4'd5;
  localparam logic [OpWidth-1:0] OpSh  = 4'd6;
  localparam logic [OpWidth-1:0] OpSw  = 4'd7;

  typedef enum logic [1:0] {
    McIdle  = 2'd0,
    McRead  = 2'd1,
    McWrite = 2'd2
  } mc_state_e;

  // Number of bus bytes an access touches; words and fetches take four.
  function automatic logic [2:0] byte_count(input logic [OpWidth-1:0] op);
    case (op)
      OpLb, OpLbu, OpSb: byte_count = 3'd1;
      OpLh, OpLhu, OpSh: byte_count = 3'd2;
      default:           byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_controller_load_extend.sv
// Assembles little-endian load bytes into a register value with sign or zero extension.
module mem_load_extend
  import memory_controller_pkg::*;
#(
  parameter int unsigned XLEN = DataWidth
) (
  input  logic [OpWidth-1:0] op_i,
  input  logic [31:0]        bytes_i,
  output logic [XLEN-1:0]    data_o
);

  always_comb begin
    data_o = XLEN'(bytes_i);
    case (op_i)
      OpLb:    data_o = {{(XLEN-8){bytes_i[7]}}, bytes_i[7:0]};
      OpLbu:   data_o = {{(XLEN-8){1'b0}}, bytes_i[7:0]};
      OpLh:    data_o = {{(XLEN-16){bytes_i[15]}}, bytes_i[15:0]};
      OpLhu:   data_o = {{(XLEN-16){1'b0}}, bytes_i[15:0]};
      default: data_o = XLEN'(bytes_i);
    endcase
  end

endmodule

// File: rtl/memory_controller.sv
// Byte-serial RAM/IO bus controller serving committed stores, LSB loads and instruction fetch.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int unsigned     XLEN     = DataWidth,
  parameter int unsigned     OP_WIDTH = OpWidth,
  parameter int unsigned     ID_WIDTH = RobIdWidth,
  parameter logic [XLEN-1:0] IO_BASE  = XLEN'(IoBase)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                io_buffer_full,
  input  logic                lsb_mem_enable,
  input  logic [OP_WIDTH-1:0] lsb_mem_op,
  input  logic [XLEN-1:0]     lsb_mem_addr,
  input  logic [ID_WIDTH-1:0] lsb_mem_id,
  input  logic                rob_store_enable,
  input  logic [OP_WIDTH-1:0] rob_store_op,
  input  logic [XLEN-1:0]     rob_store_addr,
  input  logic [XLEN-1:0]     rob_store_data,
  input  logic                if_enable,
  input  logic [XLEN-1:0]     if_addr,
  input  logic [7:0]          mem_din,
  output logic [7:0]          mem_dout,
  output logic [XLEN-1:0]     mem_a,
  output logic                mem_wr,
  output logic                mem_busy,
  output logic                mem_data_ready,
  output logic [XLEN-1:0]     mem_data,
  output logic [ID_WIDTH-1:0] mem_id,
  output logic                mem_inst_ready,
  output logic [XLEN-1:0]     mem_inst
);

  mc_state_e           state_q, state_d;
  logic [2:0]          cnt_q, cnt_d, nbytes_q, nbytes_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [XLEN-1:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                fetch_q, fetch_d, io_q, io_d;
  logic [31:0]         rbuf_q, rbuf_d;

  logic                pend_valid_q, pend_valid_d;
  logic [OP_WIDTH-1:0] pend_op_q, pend_op_d;
  logic [XLEN-1:0]     pend_addr_q, pend_addr_d;
  logic [ID_WIDTH-1:0] pend_id_q, pend_id_d;

  logic [7:0]          dout_q, dout_d;
  logic [XLEN-1:0]     a_q, a_d, data_q, data_d, inst_q, inst_d;
  logic                wr_q, wr_d, busy_q, busy_d;
  logic                data_rdy_q, data_rdy_d, inst_rdy_q, inst_rdy_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;

  logic                rd_start, rd_fetch, pend_take, lsb_take, store_io;
  logic [OP_WIDTH-1:0] rd_op;
  logic [XLEN-1:0]     rd_addr, ext_data;
  logic [ID_WIDTH-1:0] rd_id;

  assign store_io = (rob_store_addr >= IO_BASE);

  mem_load_extend #(
    .XLEN(XLEN)
  ) u_ext (
    .op_i   (op_q),
    .bytes_i(rbuf_q),
    .data_o (ext_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nbytes_d     = nbytes_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    id_d         = id_q;
    fetch_d      = fetch_q;
    io_d         = io_q;
    rbuf_d       = rbuf_q;
    pend_valid_d = pend_valid_q;
    pend_op_d    = pend_op_q;
    pend_addr_d  = pend_addr_q;
    pend_id_d    = pend_id_q;
    dout_d       = dout_q;
    a_d          = a_q;
    data_d       = data_q;
    inst_d       = inst_q;
    rid_d        = rid_q;
    // Strobes are single-cycle and also drop while rdy is low.
    wr_d         = 1'b0;
    data_rdy_d   = 1'b0;
    inst_rdy_d   = 1'b0;
    rd_start     = 1'b0;
    rd_fetch     = 1'b0;
    rd_op        = lsb_mem_op;
    rd_addr      = lsb_mem_addr;
    rd_id        = lsb_mem_id;
    pend_take    = 1'b0;
    lsb_take     = 1'b0;

    if (rdy) begin
      case (state_q)
        McIdle: begin
          if (rob_store_enable) begin
            state_d  = McWrite;
            addr_d   = rob_store_addr;
            wdata_d  = rob_store_data;
            op_d     = rob_store_op;
            nbytes_d = byte_count(rob_store_op);
            io_d     = store_io;
            cnt_d    = 3'd0;
            if (!(store_io && io_buffer_full)) begin
              a_d    = rob_store_addr;
              dout_d = rob_store_data[7:0];
              wr_d   = 1'b1;
              cnt_d  = 3'd1;
            end
          end else if (!flush) begin
            if (pend_valid_q) begin
              rd_start  = 1'b1;
              rd_op     = pend_op_q;
              rd_addr   = pend_addr_q;
              rd_id     = pend_id_q;
              pend_take = 1'b1;
            end else if (lsb_mem_enable) begin
              rd_start = 1'b1;
              lsb_take = 1'b1;
            end else if (if_enable) begin
              rd_start = 1'b1;
              rd_fetch = 1'b1;
              rd_op    = OpLw;
              rd_addr  = if_addr;
              rd_id    = '0;
            end
          end
        end
        McRead: begin
          if (flush) begin
            state_d = McIdle;
          end else if (cnt_q != nbytes_q) begin
            // RAM answers a cycle late: capture byte cnt while requesting byte cnt+1.
            rbuf_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
            if (cnt_q + 3'd1 != nbytes_q) a_d = addr_q + XLEN'(cnt_q + 3'd1);
            cnt_d = cnt_q + 3'd1;
          end else begin
            state_d = McIdle;
            if (fetch_q) begin
              inst_rdy_d = 1'b1;
              inst_d     = ext_data;
            end else begin
              data_rdy_d = 1'b1;
              data_d     = ext_data;
              rid_d      = id_q;
            end
          end
        end
        McWrite: begin
          if (cnt_q == nbytes_q) begin
            state_d = McIdle;
          end else if (!(io_q && io_buffer_full)) begin
            a_d    = addr_q + XLEN'(cnt_q);
            dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            wr_d   = 1'b1;
            cnt_d  = cnt_q + 3'd1;
          end
        end
        default: state_d = McIdle;
      endcase

      if (rd_start) begin
        state_d  = McRead;
        op_d     = rd_op;
        addr_d   = rd_addr;
        id_d     = rd_id;
        fetch_d  = rd_fetch;
        nbytes_d = byte_count(rd_op);
        cnt_d    = 3'd0;
        a_d      = rd_addr;
        rbuf_d   = '0;
      end

      if (flush) begin
        pend_valid_d = 1'b0;
      end else begin
        if (pend_take) pend_valid_d = 1'b0;
        if (lsb_mem_enable && !lsb_take) begin
          pend_valid_d = 1'b1;
          pend_op_d    = lsb_mem_op;
          pend_addr_d  = lsb_mem_addr;
          pend_id_d    = lsb_mem_id;
        end
      end
    end

    busy_d = (state_d != McIdle) || pend_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= McIdle;
      cnt_q        <= '0;
      nbytes_q     <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      id_q         <= '0;
      fetch_q      <= 1'b0;
      io_q         <= 1'b0;
      rbuf_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_op_q    <= '0;
      pend_addr_q  <= '0;
      pend_id_q    <= '0;
      dout_q       <= '0;
      a_q          <= '0;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
      data_rdy_q   <= 1'b0;
      data_q       <= '0;
      rid_q        <= '0;
      inst_rdy_q   <= 1'b0;
      inst_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nbytes_q     <= nbytes_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      id_q         <= id_d;
      fetch_q      <= fetch_d;
      io_q         <= io_d;
      rbuf_q       <= rbuf_d;
      pend_valid_q <= pend_valid_d;
      pend_op_q    <= pend_op_d;
      pend_addr_q  <= pend_addr_d;
      pend_id_q    <= pend_id_d;
      dout_q       <= dout_d;
      a_q          <= a_d;
      wr_q         <= wr_d;
      busy_q       <= busy_d;
      data_rdy_q   <= data_rdy_d;
      data_q       <= data_d;
      rid_q        <= rid_d;
      inst_rdy_q   <= inst_rdy_d;
      inst_q       <= inst_d;
    end
  end

  assign mem_dout       = dout_q;
  assign mem_a          = a_q;
  assign mem_wr         = wr_q;
  assign mem_busy       = busy_q;
  assign mem_data_ready = data_rdy_q;
  assign mem_data       = data_q;
  assign mem_id         = rid_q;
  assign mem_inst_ready = inst_rdy_q;
  assign mem_inst       = inst_q;

`ifndef SYNTHESIS
  // A load may only arrive when the one-entry slot is empty or draining this edge.
  assert property (@(posedge clk) disable iff (rst)
    !(rdy && lsb_mem_enable && !flush && pend_valid_q && !pend_take));
`endif

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: load vector table plus store, IO, flush and reset sequences.
module tb_memory_controller;
  import memory_controller_pkg::*;

  typedef struct {
    logic [OpWidth-1:0]    op;
    logic [31:0]           addr;
    logic [RobIdWidth-1:0] id;
    logic [31:0]           exp_data;
    int                    exp_lat;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  rdy = 1'b1;
  logic                  flush = 1'b0;
  logic                  io_buffer_full = 1'b0;
  logic                  lsb_mem_enable = 1'b0;
  logic [OpWidth-1:0]    lsb_mem_op = '0;
  logic [31:0]           lsb_mem_addr = '0;
  logic [RobIdWidth-1:0] lsb_mem_id = '0;
  logic                  rob_store_enable = 1'b0;
  logic [OpWidth-1:0]    rob_store_op = '0;
  logic [31:0]           rob_store_addr = '0;
  logic [31:0]           rob_store_data = '0;
  logic                  if_enable = 1'b0;
  logic [31:0]           if_addr = '0;
  logic [7:0]            mem_din, mem_dout;
  logic [31:0]           mem_a, mem_data, mem_inst;
  logic                  mem_wr, mem_busy, mem_data_ready, mem_inst_ready;
  logic [RobIdWidth-1:0] mem_id;

  logic [7:0]  ram [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  int          io_writes = 0;
  logic [7:0]  io_last = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  memory_controller dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .flush           (flush),
    .io_buffer_full  (io_buffer_full),
    .lsb_mem_enable  (lsb_mem_enable),
    .lsb_mem_op      (lsb_mem_op),
    .lsb_mem_addr    (lsb_mem_addr),
    .lsb_mem_id      (lsb_mem_id),
    .rob_store_enable(rob_store_enable),
    .rob_store_op    (rob_store_op),
    .rob_store_addr  (rob_store_addr),
    .rob_store_data  (rob_store_data),
    .if_enable       (if_enable),
    .if_addr         (if_addr),
    .mem_din         (mem_din),
    .mem_dout        (mem_dout),
    .mem_a           (mem_a),
    .mem_wr          (mem_wr),
    .mem_busy        (mem_busy),
    .mem_data_ready  (mem_data_ready),
    .mem_data        (mem_data),
    .mem_id          (mem_id),
    .mem_inst_ready  (mem_inst_ready),
    .mem_inst        (mem_inst)
  );

  always #5 clk = ~clk;

  // RAM below the IO region; read data follows mem_a combinationally (one cycle after the request).
  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_wr) begin
      if (mem_a >= 32'h0003_0000) begin
        io_writes <= io_writes + 1;
        io_last   <= mem_dout;
      end else begin
        ram[mem_a[15:0]] <= mem_dout;
      end
    end
  end
  assign mem_din = ram[mem_a[15:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_data(input int max, output int k);
    k = 0;
    while (k < max && !mem_data_ready) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic drive_load(input logic [OpWidth-1:0] op, input logic [31:0] a,
                            input logic [RobIdWidth-1:0] id);
    lsb_mem_enable = 1'b1; lsb_mem_op = op; lsb_mem_addr = a; lsb_mem_id = id;
    @(negedge clk);
    lsb_mem_enable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   k;
    int   snap;
    logic saw_data;

    vecs[0] = '{OpLw,  32'h0000_1000, 4'd5,  32'h1234_5678, 5};
    vecs[1] = '{OpLb,  32'h0000_2000, 4'd1,  32'hFFFF_FF80, 2};
    vecs[2] = '{OpLbu, 32'h0000_2000, 4'd3,  32'h0000_0080, 2};
    vecs[3] = '{OpLh,  32'h0000_1002, 4'd7,  32'h0000_1234, 3};
    vecs[4] = '{OpLh,  32'h0000_2000, 4'd2,  32'hFFFF_FF80, 3};
    vecs[5] = '{OpLhu, 32'h0000_2000, 4'd4,  32'h0000_FF80, 3};
    vecs[6] = '{OpLw,  32'hFFFF_FFFF, 4'd15, 32'h0005_13AA, 5};
    vecs[7] = '{OpLb,  32'h0000_1003, 4'd6,  32'h0000_0012, 2};

    @(negedge clk);
    poke(16'h1000, 8'h78); poke(16'h1001, 8'h56); poke(16'h1002, 8'h34); poke(16'h1003, 8'h12);
    poke(16'h2000, 8'h80); poke(16'h2001, 8'hFF); poke(16'h2002, 8'h00); poke(16'h2003, 8'h00);
    poke(16'hFFFF, 8'hAA);
    poke(16'h0000, 8'h13); poke(16'h0001, 8'h05); poke(16'h0002, 8'h00); poke(16'h0003, 8'h00);

    check("rst_mem_a", mem_a, 0);
    check("rst_mem_dout", {24'h0, mem_dout}, 0);
    check("rst_mem_wr", {31'h0, mem_wr}, 0);
    check("rst_mem_busy", {31'h0, mem_busy}, 0);
    check("rst_data_ready", {31'h0, mem_data_ready}, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_mem_id", {28'h0, mem_id}, 0);
    check("rst_inst_ready", {31'h0, mem_inst_ready}, 0);
    check("rst_mem_inst", mem_inst, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      drive_load(vecs[i].op, vecs[i].addr, vecs[i].id);
      check($sformatf("ld%0d_busy_start", i), {31'h0, mem_busy}, 1);
      wait_data(20, k);
      check($sformatf("ld%0d_ready", i), {31'h0, mem_data_ready}, 1);
      check($sformatf("ld%0d_latency", i), k, vecs[i].exp_lat);
      check($sformatf("ld%0d_data", i), mem_data, vecs[i].exp_data);
      check($sformatf("ld%0d_id", i), {28'h0, mem_id}, {28'h0, vecs[i].id});
      check($sformatf("ld%0d_busy_done", i), {31'h0, mem_busy}, 0);
      @(negedge clk);
      check($sformatf("ld%0d_ready_pulse", i), {31'h0, mem_data_ready}, 0);
    end

    // SH 0xBEEF to 0x3000
    rob_store_enable = 1'b1; rob_store_op = OpSh;
    rob_store_addr = 32'h0000_3000; rob_store_data = 32'h0000_BEEF;
    @(negedge clk);
    rob_store_enable = 1'b0;
    check("sh_wr0", {31'h0, mem_wr}, 1);
    check("sh_a0", mem_a, 32'h3000);
    check("sh_d0", {24'h0, mem_dout}, 32'hEF);
    @(negedge clk);
    check("sh_wr1", {31'h0, mem_wr}, 1);
    check("sh_a1", mem_a, 32'h3001);
    check("sh_d1", {24'h0, mem_dout}, 32'hBE);
    @(negedge clk);
    check("sh_wr_end", {31'h0, mem_wr}, 0);
    check("sh_busy_end", {31'h0, mem_busy}, 0);
    check("sh_ram0", {24'h0, ram[16'h3000]}, 32'hEF);
    check("sh_ram1", {24'h0, ram[16'h3001]}, 32'hBE);

    // Same-cycle SW and LW to 0x10: store first, then the pending load
    rob_store_enable = 1'b1; rob_store_op = OpSw;
    rob_store_addr = 32'h0000_0010; rob_store_data = 32'hCAFE_F00D;
    drive_load(OpLw, 32'h0000_0010, 4'd2);
    rob_store_enable = 1'b0;
    check("sl_wr0", {31'h0, mem_wr}, 1);
    check("sl_a0", mem_a, 32'h10);
    check("sl_d0", {24'h0, mem_dout}, 32'h0D);
    check("sl_no_early_ready", {31'h0, mem_data_ready}, 0);
    repeat (4) @(negedge clk);
    check("sl_wr_end", {31'h0, mem_wr}, 0);
    check("sl_busy_pending", {31'h0, mem_busy}, 1);
    wait_data(20, k);
    check("sl_ready", {31'h0, mem_data_ready}, 1);
    check("sl_latency", k + 4, 10);
    check("sl_data", mem_data, 32'hCAFE_F00D);
    check("sl_id", {28'h0, mem_id}, 2);
    check("sl_busy_done", {31'h0, mem_busy}, 0);
    @(negedge clk);

    // IO SB held off by io_buffer_full for three cycles
    snap = io_writes;
    io_buffer_full = 1'b1;
    rob_store_enable = 1'b1; rob_store_op = OpSb;
    rob_store_addr = 32'h0003_0000; rob_store_data = 32'h0000_0041;
    @(negedge clk);
    rob_store_enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("io_hold%0d_wr", c), {31'h0, mem_wr}, 0);
      check($sformatf("io_hold%0d_busy", c), {31'h0, mem_busy}, 1);
      if (c == 2) io_buffer_full = 1'b0;
      else @(negedge clk);
    end
    @(negedge clk);
    check("io_wr", {31'h0, mem_wr}, 1);
    check("io_a", mem_a, 32'h0003_0000);
    check("io_d", {24'h0, mem_dout}, 32'h41);
    @(negedge clk);
    check("io_wr_end", {31'h0, mem_wr}, 0);
    check("io_busy_end", {31'h0, mem_busy}, 0);
    check("io_count", io_writes - snap, 1);
    check("io_byte", {24'h0, io_last}, 32'h41);

    // LW aborted by flush at byte 2, then a fetch from 0x0
    drive_load(OpLw, 32'h0000_1000, 4'd9);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_busy", {31'h0, mem_busy}, 0);
    check("fl_wr", {31'h0, mem_wr}, 0);
    wait_data(8, k);
    check("fl_no_ready", k, 8);
    if_enable = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    k = 0;
    saw_data = 1'b0;
    while (k < 20 && !mem_inst_ready) begin
      if (mem_data_ready) saw_data = 1'b1;
      @(negedge clk);
      k++;
    end
    if_enable = 1'b0;
    check("if_ready", {31'h0, mem_inst_ready}, 1);
    check("if_latency", k, 5);
    check("if_inst", mem_inst, 32'h0000_0513);
    check("if_no_data_ready", {31'h0, saw_data | mem_data_ready}, 0);
    @(negedge clk);
    check("if_ready_pulse", {31'h0, mem_inst_ready}, 0);
    check("if_busy_end", {31'h0, mem_busy}, 0);

    // A load pulse coinciding with flush is dropped
    flush = 1'b1;
    drive_load(OpLw, 32'h0000_1000, 4'd3);
    flush = 1'b0;
    check("fd_busy", {31'h0, mem_busy}, 0);
    wait_data(8, k);
    check("fd_no_ready", k, 8);

    // Reset mid-transaction discards the load
    drive_load(OpLw, 32'h0000_1000, 4'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_busy", {31'h0, mem_busy}, 0);
    check("mr_a", mem_a, 0);
    check("mr_id", {28'h0, mem_id}, 0);
    wait_data(8, k);
    check("mr_no_ready", k, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Memory-side responder for the load/store buffer and the ROB store-commit path; also serves instruction fetch.
- Accepts one-cycle load requests (op/addr/ROB id), committed store requests and held fetch requests.
- Serialises each request into byte accesses on the 8-bit RAM/IO bus.
- Returns load results to LSB, RS and ROB via mem_data_ready/mem_data/mem_id, and fetched words to the fetch unit.

Parameters:
- XLEN, 32, data/address width (`XLEN)
- OP_WIDTH, `INST_OP_WIDTH, op encoding width; codes `LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW
- ID_WIDTH, `ROB_SIZE_WIDTH, ROB id width
- IO_BASE, 32'h30000, lowest address of the IO region (addr[17:16]==2'b11)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  misprediction flush
- io_buffer_full  in  1  IO output buffer full
- lsb_mem_enable  in  1  load request pulse
- lsb_mem_op  in  OP_WIDTH  load op
- lsb_mem_addr  in  XLEN  load address
- lsb_mem_id  in  ID_WIDTH  load ROB id
- rob_store_enable  in  1  committed store pulse
- rob_store_op  in  OP_WIDTH  store op
- rob_store_addr  in  XLEN  store address
- rob_store_data  in  XLEN  store data
- if_enable  in  1  fetch request; held until mem_inst_ready
- if_addr  in  XLEN  fetch address
- mem_din  in  8  RAM/IO read byte
- mem_dout  out  8  write byte
- mem_a  out  XLEN  byte address
- mem_wr  out  1  1 = write
- mem_busy  out  1  controller not idle, or a pending load exists
- mem_data_ready  out  1  load result valid (1 cycle)
- mem_data  out  XLEN  extended load result
- mem_id  out  ID_WIDTH  ROB id of the result
- mem_inst_ready  out  1  fetch word valid (1 cycle)
- mem_inst  out  XLEN  fetched word

Behaviour:
- Reset values: all outputs 0; state IDLE; pending slot empty.
- Requests are sampled only when rdy=1.
- States:
  - IDLE: on each edge, select by priority store > pending load > new load > fetch.
  - READ: byte k is requested at edge E(k) after the acceptance edge E0. RAM returns data one cycle late, so byte k is captured from mem_din at edge E(k+1). Bytes are stored little-endian.
  - WRITE: mem_a = addr+k, mem_dout = byte k, mem_wr = 1 at E(k).
- Byte count N: 1 for B/BU, 2 for H/HU, 4 for W and fetch.
- Load latency: mem_data_ready is high for exactly one cycle, following edge E(N+1). mem_busy falls at that same edge. The earliest next acceptance is edge E(N+2).
- Extension:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW and fetch take the full 32 bits.
- mem_id is a copy of the accepted lsb_mem_id.
- Fetch completion uses the same timing, but pulses mem_inst_ready instead of mem_data_ready.
- Store completion: mem_wr is high at E0..E(N-1). At E(N), mem_wr=0 and the controller returns to IDLE. No ready pulse is produced.
- IO stores (address ≥ IO_BASE): while io_buffer_full=1, each byte is held with mem_wr=0 and the byte counter frozen.
- Simultaneous store and load pulse: the store wins. The load is latched into a one-entry pending slot (mem_busy stays 1) and is issued at the first IDLE edge afterwards.
- A load pulse arriving while busy with an empty slot is also latched. A load pulse arriving with the slot full is a protocol error (assertion).
- Flush:
  - An in-flight read or fetch is aborted: next state IDLE, mem_wr=0, no ready pulse.
  - The pending slot is cleared.
  - A load pulse in the flush cycle is dropped.
  - An in-flight store always completes.
- mem_a wraps modulo 2^XLEN; no alignment checking.
- rst in mid-transaction discards everything, with no ready pulse.

Decomposition:
- Op codes, XLEN, ROB id width and IO_BASE already live in global_params.v.
- Add MC_IDLE/MC_READ/MC_WRITE state codes there.
- One sub-module, mem_load_extend: combinational byte assembly plus sign/zero extension from (op, bytes).

Test Plan:
- LW at 0x1000 (RAM bytes 78 56 34 12), id 5 -> mem_data_ready for one cycle, 5 cycles after acceptance, with mem_data=0x12345678 and mem_id=5.
- LB at 0x2000 containing 0x80 -> mem_data=0xFFFFFF80; LBU at the same address -> 0x00000080; each has latency 2.
- SH 0xBEEF to 0x3000 -> mem_wr=1 for 2 cycles: (0x3000, 0xEF), (0x3001, 0xBE). Then mem_busy=0.
- Same-cycle SW to 0x10 and LW from 0x10, id 2 -> the store completes first, then the load returns the just-stored value with id 2.
- SB 0x41 to 0x30000 with io_buffer_full held for 3 cycles -> mem_wr stays 0 for those cycles, then one write of 0x41 and no data lost.
- LW in flight plus flush at byte 2 -> no mem_data_ready. A fetch at 0x0 issued next gives mem_inst_ready with the correct word.
